vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Raster timing generator that produces `pixel_x`, `pixel_y` and `video_on` for the pixel/text generators, plus `hsync` and `vsync` for the VGA DAC.
- Default timing is 640x480 at 60 Hz, derived from the 50 MHz system clock through a pixel-clock enable.
- All outputs are registered, so downstream font-ROM and colour logic see glitch-free, mutually aligned coordinates.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (>=1)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- p_tick  output  1  pixel-clock enable, one clk wide
- pixel_x  output  10  current column
- pixel_y  output  10  current line
- video_on  output  1  high inside the visible region
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- frame_start  output  1  one-clk pulse at start of each frame

Behaviour:
- Derived constants:
  - H_TOTAL = sum of the four H parameters (800); V_TOTAL likewise (525).
  - Both totals must be <=1024; elaboration fails otherwise.
- Clock and reset: one clock, `clk`; `reset` is asynchronous, active-high.
  - While reset is high: divider=0, h_cnt=0, v_cnt=0, p_tick=0, pixel_x=0, pixel_y=0, video_on=0, frame_start=0.
  - hsync and vsync sit at the inactive level, ~SYNC_POL.
  - Asserting reset mid-frame forces these values immediately, with no wait for the clock.
- Divider:
  - Counts 0..CLK_DIV-1, wraps to 0.
  - p_tick is registered and is high for the one clk in which divider==CLK_DIV-1.
  - With CLK_DIV=1, p_tick is high every clk after reset release.
- Position counters (internal h_cnt, v_cnt), advancing only on clk edges where the divider is at CLK_DIV-1:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - v_cnt increments only when h_cnt wraps; at V_TOTAL-1 it wraps to 0.
  - A line wrap and a frame wrap on the same edge both take effect: (H_TOTAL-1, V_TOTAL-1) -> (0, 0).
- Output decode, registered every clk from the current h_cnt/v_cnt (one clk latency from counter to outputs, identical for all decoded outputs):
  - pixel_x = h_cnt, pixel_y = v_cnt.
  - video_on = (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY).
  - hsync = SYNC_POL when H_DISPLAY+H_FRONT <= h_cnt < H_DISPLAY+H_FRONT+H_SYNC, else ~SYNC_POL.
  - vsync = SYNC_POL when V_DISPLAY+V_FRONT <= v_cnt < V_DISPLAY+V_FRONT+V_SYNC, else ~SYNC_POL. vsync edges coincide with the pixel_x 799->0 transition.
- First clk after reset release: outputs load the decode of (0,0), i.e. video_on=1, pixel_x=0, pixel_y=0, syncs inactive.
- frame_start:
  - High for exactly one clk, the first clk in which the outputs show (0,0) after a frame wrap.
  - Not asserted for the first frame after reset.
- Output hold: outputs change only on the clk following a counter advance, so each coordinate is held for CLK_DIV clks.
- Widths: counters and outputs are 10 bits; no truncation is possible under the total constraint.

Test Plan:
- Reset held then released, defaults:
  - During reset: all outputs at reset values, hsync=vsync=1.
  - One clk after release: pixel_x=0, pixel_y=0, video_on=1.
  - p_tick first high on the 2nd clk after release, then every 2 clks.
- Line timing, defaults:
  - hsync low for exactly 96 pixel ticks, starting when pixel_x=656 and ending after pixel_x=751.
  - video_on falls when pixel_x goes 639->640.
  - pixel_x wraps 799->0 and pixel_y increments on the same clk.
- Frame timing, defaults:
  - 420000 pixel ticks (840000 clks) between consecutive frame_start pulses.
  - video_on high for exactly 307200 pixel ticks per frame.
  - vsync low while pixel_y in {490, 491}.
- Frame wrap:
  - At pixel (799, 524), the next advance yields (0,0) with frame_start=1 for one clk, and frame_start=0 on the following clk.
- Async reset mid-frame at pixel (300, 200):
  - Outputs go to reset values before the next clk edge.
  - After release, counting restarts from (0,0) with no frame_start pulse.
- CLK_DIV=1, SYNC_POL=1:
  - p_tick constantly high.
  - hsync high from pixel_x=656 to 751.
  - 420000 clks per frame.

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator for a VGA output.
//
// A clock divider produces a pixel-rate enable. Horizontal and vertical
// position counters advance on that enable. Every output is decoded from
// the counters and then registered, so all outputs share the same
// one-clock latency and are free of glitches.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   p_tick      out  pixel-clock enable, one clk wide
//   pixel_x     out  current column (10 bits)
//   pixel_y     out  current line (10 bits)
//   video_on    out  high inside the visible region
//   hsync       out  horizontal sync, active level SYNC_POL
//   vsync       out  vertical sync, active level SYNC_POL
//   frame_start out  one-clk pulse when the outputs first show (0,0)
//                    after a frame wrap; not asserted for the first
//                    frame after reset
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Reject timings that cannot be represented in the 10-bit counters.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must both be <= 1024");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_sync_gen: CLK_DIV must be >= 1");
    end

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Decode boundaries are 11 bits wide because a sync window may end
    // exactly at 1024.
    localparam logic [10:0] H_VIS       = 11'(H_DISPLAY);
    localparam logic [10:0] H_SYNC_BEG  = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] H_SYNC_END  = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS       = 11'(V_DISPLAY);
    localparam logic [10:0] V_SYNC_BEG  = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] V_SYNC_END  = 11'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] divider;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             advance;
    logic             line_end;
    logic             frame_end;
    logic             wrap_pending;
    logic [10:0]      h_ext;
    logic [10:0]      v_ext;
    logic             h_active;
    logic             v_active;

    assign advance   = (divider == DIV_LAST);
    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = (v_cnt == V_LAST);
    assign h_ext     = {1'b0, h_cnt};
    assign v_ext     = {1'b0, v_cnt};
    assign h_active  = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
    assign v_active  = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);

    // Pixel-rate divider; with CLK_DIV=1 it sits at 0 and advance is constant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divider <= '0;
        end else if (advance) begin
            divider <= '0;
        end else begin
            divider <= divider + 1'b1;
        end
    end

    // Position counters. A line wrap on the last line also wraps the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (advance) begin
            if (line_end) begin
                h_cnt <= '0;
                v_cnt <= frame_end ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Registered decode. wrap_pending marks the clk in which the counters
    // have just wrapped to (0,0); the outputs show (0,0) one clk later, which
    // is when frame_start fires. Nothing sets it before the first wrap, so
    // the frame following reset produces no pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_tick       <= 1'b0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            video_on     <= 1'b0;
            hsync        <= ~SYNC_POL;
            vsync        <= ~SYNC_POL;
            wrap_pending <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            p_tick       <= advance;
            pixel_x      <= h_cnt;
            pixel_y      <= v_cnt;
            video_on     <= (h_ext < H_VIS) && (v_ext < V_VIS);
            hsync        <= h_active ? SYNC_POL : ~SYNC_POL;
            vsync        <= v_active ? SYNC_POL : ~SYNC_POL;
            wrap_pending <= advance && line_end && frame_end;
            frame_start  <= wrap_pending;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen. Three instances run side by side:
//   u_def   default 640x480 timing, CLK_DIV=2, active-low syncs
//   u_small reduced 34x21 raster, CLK_DIV=2, active-low syncs
//   u_fast  reduced 34x21 raster, CLK_DIV=1, active-high syncs
// A model derives every output from the clk count since reset release.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d, rst_s, rst_f;

    logic       d_tick, d_von, d_hs, d_vs, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_tick, s_von, s_hs, s_vs, s_fs;
    logic [9:0] s_x, s_y;
    logic       f_tick, f_von, f_hs, f_vs, f_fs;
    logic [9:0] f_x, f_y;

    vga_sync_gen u_def (
        .clk(clk), .reset(rst_d), .p_tick(d_tick), .pixel_x(d_x), .pixel_y(d_y),
        .video_on(d_von), .hsync(d_hs), .vsync(d_vs), .frame_start(d_fs)
    );

    vga_sync_gen #(
        .H_DISPLAY(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_DISPLAY(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(4),
        .CLK_DIV(2), .SYNC_POL(1'b0)
    ) u_small (
        .clk(clk), .reset(rst_s), .p_tick(s_tick), .pixel_x(s_x), .pixel_y(s_y),
        .video_on(s_von), .hsync(s_hs), .vsync(s_vs), .frame_start(s_fs)
    );

    vga_sync_gen #(
        .H_DISPLAY(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_DISPLAY(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(4),
        .CLK_DIV(1), .SYNC_POL(1'b1)
    ) u_fast (
        .clk(clk), .reset(rst_f), .p_tick(f_tick), .pixel_x(f_x), .pixel_y(f_y),
        .video_on(f_von), .hsync(f_hs), .vsync(f_vs), .frame_start(f_fs)
    );

    typedef struct {
        int hd, hf, hs, hb, vd, vf, vs, vb, div;
        bit pol;
    } timing_t;

    typedef struct {
        logic       tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       von, hs, vs, fs;
    } obs_t;

    timing_t t_def   = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0};
    timing_t t_small = '{20, 4, 6, 4, 12, 3, 2, 4, 2, 1'b0};
    timing_t t_fast  = '{20, 4, 6, 4, 12, 3, 2, 4, 1, 1'b1};

    int n_checks = 0;
    int n_err    = 0;

    // Clk edges since reset release, as seen after each edge.
    int cyc_d, cyc_s, cyc_f;
    always @(posedge clk or posedge rst_d) if (rst_d) cyc_d <= 0; else cyc_d <= cyc_d + 1;
    always @(posedge clk or posedge rst_s) if (rst_s) cyc_s <= 0; else cyc_s <= cyc_s + 1;
    always @(posedge clk or posedge rst_f) if (rst_f) cyc_f <= 0; else cyc_f <= cyc_f + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // After c clk edges, the outputs show the position reached after
    // floor((c-1)/div) pixel ticks. Pixel ticks complete on edges c that are
    // multiples of div. frame_start marks the first clk showing (0,0) of any
    // frame but the first.
    function automatic obs_t model(input timing_t p, input int c, input bit in_rst);
        obs_t o;
        int ht, vt, t, tf, x, y;
        ht = p.hd + p.hf + p.hs + p.hb;
        vt = p.vd + p.vf + p.vs + p.vb;
        o.tick = 1'b0; o.x = '0; o.y = '0; o.von = 1'b0;
        o.hs = ~p.pol; o.vs = ~p.pol; o.fs = 1'b0;
        if (!in_rst && c > 0) begin
            t  = (c - 1) / p.div;
            tf = t % (ht * vt);
            x  = tf % ht;
            y  = tf / ht;
            o.tick = (c % p.div == 0);
            o.x    = 10'(x);
            o.y    = 10'(y);
            o.von  = (x < p.hd) && (y < p.vd);
            o.hs   = (x >= p.hd + p.hf && x < p.hd + p.hf + p.hs) ? p.pol : ~p.pol;
            o.vs   = (y >= p.vd + p.vf && y < p.vd + p.vf + p.vs) ? p.pol : ~p.pol;
            o.fs   = (t > 0) && (tf == 0) && ((c - 1) % p.div == 0);
        end
        return o;
    endfunction

    function automatic obs_t mk(input logic tick, input logic [9:0] x, input logic [9:0] y,
                                input logic von, input logic hs, input logic vs, input logic fs);
        obs_t o;
        o.tick = tick; o.x = x; o.y = y; o.von = von; o.hs = hs; o.vs = vs; o.fs = fs;
        return o;
    endfunction

    task automatic cmp(input string tag, input obs_t a, input obs_t e);
        check({tag, ".p_tick"},      16'(a.tick), 16'(e.tick));
        check({tag, ".pixel_x"},     16'(a.x),    16'(e.x));
        check({tag, ".pixel_y"},     16'(a.y),    16'(e.y));
        check({tag, ".video_on"},    16'(a.von),  16'(e.von));
        check({tag, ".hsync"},       16'(a.hs),   16'(e.hs));
        check({tag, ".vsync"},       16'(a.vs),   16'(e.vs));
        check({tag, ".frame_start"}, 16'(a.fs),   16'(e.fs));
    endtask

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        cmp("def",   mk(d_tick, d_x, d_y, d_von, d_hs, d_vs, d_fs), model(t_def,   cyc_d, rst_d));
        cmp("small", mk(s_tick, s_x, s_y, s_von, s_hs, s_vs, s_fs), model(t_small, cyc_s, rst_s));
        cmp("fast",  mk(f_tick, f_x, f_y, f_von, f_hs, f_vs, f_fs), model(t_fast,  cyc_f, rst_f));
    end

    // Default timing: hsync window, video_on edge and line wrap on line 0.
    task automatic def_thread();
        int low_cnt = 0, first_low = -1, last_low = -1, fall_x = -1, wrap_y = -1;
        logic prev_von;
        logic [9:0] px;
        prev_von = d_von;
        px = d_x;
        while (cyc_d < 3210) begin
            @(negedge clk);
            if (d_y == 10'd0 && d_hs == 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = int'(d_x);
                last_low = int'(d_x);
            end
            if (prev_von && !d_von && fall_x < 0) fall_x = int'(d_x);
            if (px == 10'd799 && d_x == 10'd0 && wrap_y < 0) wrap_y = int'(d_y);
            prev_von = d_von;
            px = d_x;
        end
        check("def_hsync_low_clks", 16'(low_cnt),   16'd192);
        check("def_hsync_first_x",  16'(first_low), 16'd656);
        check("def_hsync_last_x",   16'(last_low),  16'd751);
        check("def_von_fall_x",     16'(fall_x),    16'd640);
        check("def_wrap_y",         16'(wrap_y),    16'd1);
    endtask

    // Reduced raster, CLK_DIV=2: frame wrap, frame period, visible area,
    // then an asynchronous reset mid-frame.
    task automatic small_thread();
        int fs_c[$];
        int von_clks = 0, early = 0, budget;
        logic prev_fs = 1'b0;
        logic [9:0] px, py;
        px = s_x;
        py = s_y;
        while (fs_c.size() < 2 && cyc_s < 4000) begin
            @(negedge clk);
            if (prev_fs) check("small_fs_next_clk", 16'(s_fs), 16'd0);
            if (s_fs) begin
                fs_c.push_back(cyc_s);
                check("small_wrap_prev_x", 16'(px),  16'd33);
                check("small_wrap_prev_y", 16'(py),  16'd20);
                check("small_wrap_x",      16'(s_x), 16'd0);
                check("small_wrap_y",      16'(s_y), 16'd0);
            end
            if (fs_c.size() == 1 && s_von) von_clks++;
            prev_fs = s_fs;
            px = s_x;
            py = s_y;
        end
        check("small_fs_count", 16'(fs_c.size()), 16'd2);
        if (fs_c.size() == 2) begin
            check("small_fs_first_clk", 16'(fs_c[0]),           16'd1429);
            check("small_fs_period",    16'(fs_c[1] - fs_c[0]), 16'd1428);
            check("small_von_clks",     16'(von_clks),          16'd480);
        end

        budget = 0;
        while (!(s_x == 10'd10 && s_y == 10'd5) && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        check("small_reach_10_5", 16'(budget < 2000), 16'd1);

        #2 rst_s = 1'b1;
        #1;
        check("mid_rst_p_tick",      16'(s_tick), 16'd0);
        check("mid_rst_pixel_x",     16'(s_x),    16'd0);
        check("mid_rst_pixel_y",     16'(s_y),    16'd0);
        check("mid_rst_video_on",    16'(s_von),  16'd0);
        check("mid_rst_hsync",       16'(s_hs),   16'd1);
        check("mid_rst_vsync",       16'(s_vs),   16'd1);
        check("mid_rst_frame_start", 16'(s_fs),   16'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_s = 1'b0;
        for (int k = 1; k <= 1428; k++) begin
            @(negedge clk);
            if (s_fs) early++;
        end
        check("post_rst_no_fs", 16'(early), 16'd0);
        @(negedge clk);
        check("post_rst_fs_1429", 16'(s_fs), 16'd1);
    endtask

    // Reduced raster, CLK_DIV=1, active-high syncs.
    task automatic fast_thread();
        int fs_c[$];
        int tick_low = 0, hs_cnt = 0, hs_first = -1, hs_last = -1;
        while (fs_c.size() < 2 && cyc_f < 2000) begin
            @(negedge clk);
            if (!f_tick) tick_low++;
            if (fs_c.size() == 0 && f_y == 10'd0 && f_hs) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(f_x);
                hs_last = int'(f_x);
            end
            if (f_fs) fs_c.push_back(cyc_f);
        end
        check("fast_tick_low",  16'(tick_low), 16'd0);
        check("fast_hs_clks",   16'(hs_cnt),   16'd6);
        check("fast_hs_first",  16'(hs_first), 16'd24);
        check("fast_hs_last",   16'(hs_last),  16'd29);
        check("fast_fs_count",  16'(fs_c.size()), 16'd2);
        if (fs_c.size() == 2) begin
            check("fast_fs_first_clk", 16'(fs_c[0]),           16'd715);
            check("fast_fs_period",    16'(fs_c[1] - fs_c[0]), 16'd714);
        end
    endtask

    initial begin
        rst_d = 1'b1;
        rst_s = 1'b1;
        rst_f = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_p_tick",      16'(d_tick), 16'd0);
        check("rst_pixel_x",     16'(d_x),    16'd0);
        check("rst_pixel_y",     16'(d_y),    16'd0);
        check("rst_video_on",    16'(d_von),  16'd0);
        check("rst_hsync",       16'(d_hs),   16'd1);
        check("rst_vsync",       16'(d_vs),   16'd1);
        check("rst_frame_start", 16'(d_fs),   16'd0);
        check("rst_fast_hsync",  16'(f_hs),   16'd0);

        #2;
        rst_d = 1'b0;
        rst_s = 1'b0;
        rst_f = 1'b0;

        @(negedge clk);
        check("clk1_pixel_x",  16'(d_x),    16'd0);
        check("clk1_pixel_y",  16'(d_y),    16'd0);
        check("clk1_video_on", 16'(d_von),  16'd1);
        check("clk1_p_tick",   16'(d_tick), 16'd0);
        check("clk1_hsync",    16'(d_hs),   16'd1);
        check("clk1_fast_tick", 16'(f_tick), 16'd1);
        @(negedge clk);
        check("clk2_p_tick",  16'(d_tick), 16'd1);
        check("clk2_pixel_x", 16'(d_x),    16'd0);
        @(negedge clk);
        check("clk3_p_tick",  16'(d_tick), 16'd0);
        check("clk3_pixel_x", 16'(d_x),    16'd1);
        @(negedge clk);
        check("clk4_p_tick",  16'(d_tick), 16'd1);

        fork
            def_thread();
            small_thread();
            fast_thread();
        join

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
